vec_issue_ctrl: RTL and testbench
=================================

VEC_ISSUE_CTRL -- requirements
Module: vec_issue_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_REGS, default 32, giving the number of vector registers tracked by the scoreboard.
REQ-002 The block SHALL have parameter MVL, default 32, giving the maximum vector length.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port instr_i, input, 32 bits: instruction at the head of the instruction FIFO.
REQ-006 The block SHALL have port empty_i, input, 1 bit: FIFO empty; instr_i is invalid while it is 1.
REQ-007 The block SHALL have port stalling_o, output, 1 bit: combinational stall back to the FIFO.
REQ-008 The block SHALL have port unit_ready_i, input, 3 bits: per-unit ready, bit0 ALU, bit1 MUL, bit2 MEM.
REQ-009 The block SHALL have ports wb_valid_i, input, 1 bit, and wb_vd_i, input, 5 bits: a completion releases register wb_vd_i.
REQ-010 The block SHALL have ports issue_valid_o, output, 1 bit, and issue_unit_o, output, 2 bits (0 ALU, 1 MUL, 2 MEM).
REQ-011 The block SHALL have ports issue_op_o, output, 3 bits (0 ADD, 1 SUB, 2 CMP, 3 MUL, 4 LOAD, 5 STORE), and issue_vd_o/issue_vs1_o/issue_vs2_o, output, 5 bits each.
REQ-012 The block SHALL have port issue_vl_o, output, clog2(MVL+1) bits: the vector length attached to the issued instruction.
REQ-013 The block SHALL have ports illegal_o, output, 1 bit (one-cycle pulse), busy_o, output, NUM_REGS bits (scoreboard), and stall_cycles_o, output, 32 bits.

Function
REQ-014 Decode SHALL use RISC-V V fields: opcode [6:0], vd [11:7], funct3 [14:12], vs1/uimm [19:15], vs2 [24:20], funct6 [31:26].
REQ-015 Opcode 0x57 with funct3 != 7 SHALL map as: funct6 0x00 -> ADD, 0x02 -> SUB, 0x18 -> CMP (all ALU), 0x25 -> MUL (MUL unit).
REQ-016 Opcode 0x07 SHALL map to LOAD and opcode 0x27 to STORE, both on the MEM unit; STORE reads vd as a source and writes no register.
REQ-017 Opcode 0x57 with funct3 = 7 and instr[31:30] = 2'b11 (vsetivli) SHALL set vl <= min(uimm, MVL), issue nothing, and never stall.
REQ-018 Any other encoding SHALL be consumed without stalling, pulse illegal_o for 1 cycle, and issue nothing.
REQ-019 Hazard SHALL be asserted when any of the following holds: a used source register is busy (RAW), vd is busy for a register-writing op (WAW), or unit_ready_i of the target unit is 0.
REQ-020 stalling_o SHALL equal hazard AND NOT empty_i; it is purely combinational and is 0 whenever empty_i = 1.
REQ-021 The head instruction SHALL be consumed in a cycle where empty_i = 0 and stalling_o = 0.
REQ-022 A consumed issuable instruction SHALL produce exactly one issue_valid_o = 1 cycle on the next edge, with all issue_* fields registered (latency 1).
REQ-023 While issue_valid_o = 0, the issue_* fields SHALL hold their last values.
REQ-024 On issue of a register-writing op, busy[vd] SHALL be set on the same edge as issue.
REQ-025 wb_valid_i SHALL clear busy[wb_vd_i] on the next edge; a writeback to a non-busy register has no effect.
REQ-026 Set and clear of different bits on the same edge SHALL both take effect.
REQ-027 There SHALL be no scoreboard bypass: an instruction waiting on reg X issues at the earliest one cycle after the edge that clears busy[X].
REQ-028 stall_cycles_o SHALL increment on each edge with stalling_o = 1, saturating at 0xFFFFFFFF.

Reset
REQ-029 On rst = 1 at a clock edge, busy_o SHALL become 0, vl SHALL become MVL, stall_cycles_o SHALL become 0, issue_valid_o/illegal_o SHALL become 0, and issue_* fields SHALL become 0.
REQ-030 A reset asserted mid-operation SHALL drop any pending issue, and no instruction SHALL be consumed in the reset cycle.
REQ-031 Writebacks arriving after reset for registers issued before reset SHALL be harmless (no-op per REQ-025).

Structure
REQ-032 Opcode/funct6 constants, the unit encoding, and the op encoding SHALL reside in a shared vector-unit package.
REQ-033 Decode SHALL be one combinational sub-module, vec_decode, outputting class, op, used-source flags, and writes-vd.
REQ-034 Scoreboard, vl register, issue register, and stall counter SHALL be in vec_issue_ctrl.

Verification
REQ-035 Scenario: vadd vd=3 with all units ready, empty_i = 0 -> stalling_o = 0, next cycle issue_valid_o = 1, op = ADD, vd = 3, busy_o[3] = 1.
REQ-036 Scenario: vmul vd=4 reading v3 while busy[3] = 1, then wb_vd_i = 3 at cycle N -> stall through cycle N, issue_valid_o = 1 at cycle N+2, stall_cycles_o equals the stalled cycle count.
REQ-037 Scenario: vsetivli uimm = 20, then a load -> no issue for the vsetivli, the load issues with issue_vl_o = 20; vsetivli uimm = 31 with MVL = 16 -> vl = 16.
REQ-038 Scenario: unit_ready_i = 3'b011 with a store at the head -> stall until bit2 = 1; after issue, busy_o is unchanged.
REQ-039 Scenario: instr_i = 0xFFFFFFFF -> illegal_o pulses 1 cycle, no stall, no issue.
REQ-040 Scenario: rst asserted while busy_o = 0x18 and an issue is pending -> busy_o = 0, issue_valid_o = 0, and vl = MVL next cycle.

Source files
------------

// File: rtl/vec_issue_ctrl_pkg.sv
// Shared vector-unit encodings: major opcodes, funct6 values, unit and op codes,
// and the decode classification used by the issue controller.
package vec_issue_ctrl_pkg;

  localparam logic [6:0] OPC_OPV   = 7'h57;
  localparam logic [6:0] OPC_LOAD  = 7'h07;
  localparam logic [6:0] OPC_STORE = 7'h27;

  localparam logic [5:0] F6_ADD = 6'h00;
  localparam logic [5:0] F6_SUB = 6'h02;
  localparam logic [5:0] F6_CMP = 6'h18;
  localparam logic [5:0] F6_MUL = 6'h25;

  localparam logic [2:0] F3_OPCFG = 3'b111;

  typedef enum logic [1:0] {
    UNIT_ALU = 2'd0,
    UNIT_MUL = 2'd1,
    UNIT_MEM = 2'd2
  } unit_e;

  typedef enum logic [2:0] {
    OP_ADD   = 3'd0,
    OP_SUB   = 3'd1,
    OP_CMP   = 3'd2,
    OP_MUL   = 3'd3,
    OP_LOAD  = 3'd4,
    OP_STORE = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    CLS_ISSUE   = 2'd0,
    CLS_VSET    = 2'd1,
    CLS_ILLEGAL = 2'd2
  } cls_e;

endpackage

// File: rtl/vec_issue_ctrl_decode.sv
// Combinational decode of the FIFO head: instruction class, target unit, op,
// which vector registers are read, and whether vd is written.
module vec_decode
  import vec_issue_ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output logic [1:0]  cls,
  output logic [1:0]  unit,
  output logic [2:0]  op,
  output logic        use_vs1,
  output logic        use_vs2,
  output logic        use_vd,
  output logic        writes_vd
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [5:0] funct6;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct6 = instr[31:26];

  always_comb begin
    cls       = CLS_ILLEGAL;
    unit      = UNIT_ALU;
    op        = OP_ADD;
    use_vs1   = 1'b0;
    use_vs2   = 1'b0;
    use_vd    = 1'b0;
    writes_vd = 1'b0;
    unique case (opcode)
      OPC_OPV: begin
        if (funct3 == F3_OPCFG) begin
          if (instr[31:30] == 2'b11) cls = CLS_VSET;
        end else begin
          cls       = CLS_ISSUE;
          writes_vd = 1'b1;
          use_vs2   = 1'b1;
          // vs1 is a vector register only for the .vv forms; otherwise it is a scalar or immediate
          use_vs1   = (funct3 == 3'd0) || (funct3 == 3'd1) || (funct3 == 3'd2);
          unique case (funct6)
            F6_ADD:  op = OP_ADD;
            F6_SUB:  op = OP_SUB;
            F6_CMP:  op = OP_CMP;
            F6_MUL: begin
              op   = OP_MUL;
              unit = UNIT_MUL;
            end
            default: begin
              cls       = CLS_ILLEGAL;
              writes_vd = 1'b0;
              use_vs1   = 1'b0;
              use_vs2   = 1'b0;
            end
          endcase
        end
      end
      OPC_LOAD: begin
        cls       = CLS_ISSUE;
        unit      = UNIT_MEM;
        op        = OP_LOAD;
        writes_vd = 1'b1;
      end
      OPC_STORE: begin
        cls    = CLS_ISSUE;
        unit   = UNIT_MEM;
        op     = OP_STORE;
        use_vd = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/vec_issue_ctrl.sv
// In-order vector issue controller: register scoreboard, vl register, registered
// issue port and saturating stall counter, fed from an instruction FIFO head.
module vec_issue_ctrl
  import vec_issue_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned MVL      = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [31:0]                instr_i,
  input  logic                       empty_i,
  output logic                       stalling_o,
  input  logic [2:0]                 unit_ready_i,
  input  logic                       wb_valid_i,
  input  logic [4:0]                 wb_vd_i,
  output logic                       issue_valid_o,
  output logic [1:0]                 issue_unit_o,
  output logic [2:0]                 issue_op_o,
  output logic [4:0]                 issue_vd_o,
  output logic [4:0]                 issue_vs1_o,
  output logic [4:0]                 issue_vs2_o,
  output logic [$clog2(MVL+1)-1:0]   issue_vl_o,
  output logic                       illegal_o,
  output logic [NUM_REGS-1:0]        busy_o,
  output logic [31:0]                stall_cycles_o
);

  localparam int unsigned VLW = $clog2(MVL + 1);

  logic [1:0]          cls;
  logic [1:0]          unit;
  logic [2:0]          op;
  logic                use_vs1;
  logic                use_vs2;
  logic                use_vd;
  logic                writes_vd;
  logic [4:0]          vd;
  logic [4:0]          vs1;
  logic [4:0]          vs2;
  logic                hazard;
  logic                consume;
  logic [VLW-1:0]      vl;
  logic [VLW-1:0]      vl_req;
  logic [NUM_REGS-1:0] busy_nxt;

  assign vd  = instr_i[11:7];
  assign vs1 = instr_i[19:15];
  assign vs2 = instr_i[24:20];

  vec_decode u_decode (
    .instr     (instr_i),
    .cls       (cls),
    .unit      (unit),
    .op        (op),
    .use_vs1   (use_vs1),
    .use_vs2   (use_vs2),
    .use_vd    (use_vd),
    .writes_vd (writes_vd)
  );

  always_comb begin
    hazard = 1'b0;
    if (cls == CLS_ISSUE) begin
      hazard = (use_vs1 && busy_o[vs1]) ||
               (use_vs2 && busy_o[vs2]) ||
               ((use_vd || writes_vd) && busy_o[vd]) ||
               !unit_ready_i[unit];
    end
  end

  assign stalling_o = hazard && !empty_i;
  assign consume    = !empty_i && !stalling_o && !rst;

  always_comb begin
    vl_req = VLW'(vs1);
    if (32'(vs1) > MVL) vl_req = VLW'(MVL);
  end

  // Writeback clear is applied before the issue set so both land on the same edge
  always_comb begin
    busy_nxt = busy_o;
    if (wb_valid_i) busy_nxt[wb_vd_i] = 1'b0;
    if (consume && cls == CLS_ISSUE && writes_vd) busy_nxt[vd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_o         <= '0;
      vl             <= VLW'(MVL);
      stall_cycles_o <= '0;
      issue_valid_o  <= 1'b0;
      illegal_o      <= 1'b0;
      issue_unit_o   <= '0;
      issue_op_o     <= '0;
      issue_vd_o     <= '0;
      issue_vs1_o    <= '0;
      issue_vs2_o    <= '0;
      issue_vl_o     <= '0;
    end else begin
      busy_o        <= busy_nxt;
      issue_valid_o <= 1'b0;
      illegal_o     <= 1'b0;
      if (stalling_o && stall_cycles_o != '1) stall_cycles_o <= stall_cycles_o + 32'd1;
      if (consume) begin
        unique case (cls)
          CLS_ISSUE: begin
            issue_valid_o <= 1'b1;
            issue_unit_o  <= unit;
            issue_op_o    <= op;
            issue_vd_o    <= vd;
            issue_vs1_o   <= vs1;
            issue_vs2_o   <= vs2;
            issue_vl_o    <= vl;
          end
          CLS_VSET: vl        <= vl_req;
          default:  illegal_o <= 1'b1;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vec_issue_ctrl.sv
// Directed bench for vec_issue_ctrl: a default instance (MVL=32) and an MVL=16
// instance share all stimulus; expected values are hand-computed per step.
module tb_vec_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        empty;
  logic [2:0]  unit_ready;
  logic        wb_valid;
  logic [4:0]  wb_vd;

  logic        stalling, issue_valid, illegal;
  logic [1:0]  issue_unit;
  logic [2:0]  issue_op;
  logic [4:0]  issue_vd, issue_vs1, issue_vs2;
  logic [5:0]  issue_vl;
  logic [31:0] busy, stall_cycles;

  logic        stalling16, issue_valid16, illegal16;
  logic [1:0]  issue_unit16;
  logic [2:0]  issue_op16;
  logic [4:0]  issue_vd16, issue_vs116, issue_vs216;
  logic [4:0]  issue_vl16;
  logic [31:0] busy16, stall_cycles16;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  vec_issue_ctrl u_dut (
    .clk(clk), .rst(rst), .instr_i(instr), .empty_i(empty), .stalling_o(stalling),
    .unit_ready_i(unit_ready), .wb_valid_i(wb_valid), .wb_vd_i(wb_vd),
    .issue_valid_o(issue_valid), .issue_unit_o(issue_unit), .issue_op_o(issue_op),
    .issue_vd_o(issue_vd), .issue_vs1_o(issue_vs1), .issue_vs2_o(issue_vs2),
    .issue_vl_o(issue_vl), .illegal_o(illegal), .busy_o(busy), .stall_cycles_o(stall_cycles)
  );

  vec_issue_ctrl #(.MVL(16)) u_dut16 (
    .clk(clk), .rst(rst), .instr_i(instr), .empty_i(empty), .stalling_o(stalling16),
    .unit_ready_i(unit_ready), .wb_valid_i(wb_valid), .wb_vd_i(wb_vd),
    .issue_valid_o(issue_valid16), .issue_unit_o(issue_unit16), .issue_op_o(issue_op16),
    .issue_vd_o(issue_vd16), .issue_vs1_o(issue_vs116), .issue_vs2_o(issue_vs216),
    .issue_vl_o(issue_vl16), .illegal_o(illegal16), .busy_o(busy16), .stall_cycles_o(stall_cycles16)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] vop(input logic [5:0] f6, input logic [2:0] f3,
                                      input logic [4:0] vd, input logic [4:0] vs1,
                                      input logic [4:0] vs2);
    return {f6, 1'b1, vs2, vs1, f3, vd, 7'h57};
  endfunction

  function automatic logic [31:0] vmem(input logic [6:0] opc, input logic [4:0] vd);
    return {12'h020, 5'd1, 3'b000, vd, opc};
  endfunction

  function automatic logic [31:0] vseti(input logic [4:0] uimm);
    return {2'b11, 10'h000, uimm, 3'b111, 5'd0, 7'h57};
  endfunction

  initial begin
    rst = 1'b1; instr = '0; empty = 1'b1; unit_ready = 3'b111; wb_valid = 1'b0; wb_vd = '0;
    step(); step();
    rst = 1'b0;
    check("rst_busy", busy, 32'h0);
    check("rst_issue_valid", {31'b0, issue_valid}, 32'd0);
    check("rst_stall_cycles", stall_cycles, 32'd0);
    check("rst_illegal", {31'b0, illegal}, 32'd0);
    check("rst_issue_vd", {27'b0, issue_vd}, 32'd0);

    // vadd.vv v3, v2, v1
    instr = vop(6'h00, 3'd0, 5'd3, 5'd1, 5'd2); empty = 1'b0;
    @(negedge clk);
    check("add_stall", {31'b0, stalling}, 32'd0);
    step(); empty = 1'b1;
    check("add_valid", {31'b0, issue_valid}, 32'd1);
    check("add_op", {29'b0, issue_op}, 32'd0);
    check("add_unit", {30'b0, issue_unit}, 32'd0);
    check("add_vd", {27'b0, issue_vd}, 32'd3);
    check("add_vl", {26'b0, issue_vl}, 32'd32);
    check("add_vl16", {27'b0, issue_vl16}, 32'd16);
    check("add_busy", busy, 32'h08);
    step();
    check("hold_valid", {31'b0, issue_valid}, 32'd0);
    check("hold_vd", {27'b0, issue_vd}, 32'd3);

    // empty FIFO masks a hazard
    instr = vop(6'h00, 3'd0, 5'd5, 5'd3, 5'd2);
    @(negedge clk);
    check("empty_no_stall", {31'b0, stalling}, 32'd0);

    // vmul.vv v4, v5, v3: RAW on v3 until writeback
    step();
    instr = vop(6'h25, 3'd2, 5'd4, 5'd3, 5'd5); empty = 1'b0;
    @(negedge clk);
    check("mul_stall0", {31'b0, stalling}, 32'd1);
    step(); step();
    wb_valid = 1'b1; wb_vd = 5'd3;
    @(negedge clk);
    check("mul_stall_wb", {31'b0, stalling}, 32'd1);
    step(); wb_valid = 1'b0;
    @(negedge clk);
    check("mul_stall_released", {31'b0, stalling}, 32'd0);
    check("mul_busy_cleared", busy, 32'h0);
    check("mul_not_yet", {31'b0, issue_valid}, 32'd0);
    step(); empty = 1'b1;
    check("mul_valid", {31'b0, issue_valid}, 32'd1);
    check("mul_op", {29'b0, issue_op}, 32'd3);
    check("mul_unit", {30'b0, issue_unit}, 32'd1);
    check("mul_vd", {27'b0, issue_vd}, 32'd4);
    check("mul_stall_cycles", stall_cycles, 32'd3);
    check("mul_busy", busy, 32'h10);

    // vsetivli 20 then a load
    instr = vseti(5'd20); empty = 1'b0;
    @(negedge clk);
    check("vset_stall", {31'b0, stalling}, 32'd0);
    step();
    check("vset_no_issue", {31'b0, issue_valid}, 32'd0);
    check("vset_no_illegal", {31'b0, illegal}, 32'd0);
    instr = vmem(7'h07, 5'd6);
    step(); empty = 1'b1;
    check("ld_valid", {31'b0, issue_valid}, 32'd1);
    check("ld_op", {29'b0, issue_op}, 32'd4);
    check("ld_unit", {30'b0, issue_unit}, 32'd2);
    check("ld_vl", {26'b0, issue_vl}, 32'd20);
    check("ld_vl16", {27'b0, issue_vl16}, 32'd16);
    check("ld_busy", busy, 32'h50);

    instr = vseti(5'd31); empty = 1'b0;
    step();
    instr = vmem(7'h07, 5'd7);
    step(); empty = 1'b1;
    check("ld31_vl", {26'b0, issue_vl}, 32'd31);
    check("ld31_vl16", {27'b0, issue_vl16}, 32'd16);
    check("ld31_busy", busy, 32'hD0);

    // store with MEM unit not ready
    unit_ready = 3'b011; instr = vmem(7'h27, 5'd8); empty = 1'b0;
    @(negedge clk);
    check("st_stall", {31'b0, stalling}, 32'd1);
    step(); step();
    check("st_no_issue", {31'b0, issue_valid}, 32'd0);
    unit_ready = 3'b111;
    @(negedge clk);
    check("st_released", {31'b0, stalling}, 32'd0);
    step(); empty = 1'b1;
    check("st_valid", {31'b0, issue_valid}, 32'd1);
    check("st_op", {29'b0, issue_op}, 32'd5);
    check("st_busy", busy, 32'hD0);
    check("st_stall_cycles", stall_cycles, 32'd5);

    // illegal encoding
    instr = 32'hFFFF_FFFF; empty = 1'b0;
    @(negedge clk);
    check("ill_stall", {31'b0, stalling}, 32'd0);
    step(); empty = 1'b1;
    check("ill_pulse", {31'b0, illegal}, 32'd1);
    check("ill_no_issue", {31'b0, issue_valid}, 32'd0);
    step();
    check("ill_pulse_end", {31'b0, illegal}, 32'd0);

    // writeback to an idle register, then set and clear on one edge
    wb_valid = 1'b1; wb_vd = 5'd9;
    step();
    check("wb_idle_reg", busy, 32'hD0);
    instr = vop(6'h02, 3'd0, 5'd9, 5'd1, 5'd2); empty = 1'b0; wb_vd = 5'd4;
    step(); empty = 1'b1; wb_valid = 1'b0;
    check("sub_valid", {31'b0, issue_valid}, 32'd1);
    check("sub_op", {29'b0, issue_op}, 32'd1);
    check("set_and_clear", busy, 32'h2C0);

    // reset mid-operation
    rst = 1'b1;
    step(); rst = 1'b0;
    instr = vseti(5'd7); empty = 1'b0;
    step();
    instr = vop(6'h00, 3'd0, 5'd3, 5'd1, 5'd2);
    step();
    check("pre_rst_vl", {26'b0, issue_vl}, 32'd7);
    instr = vop(6'h18, 3'd0, 5'd4, 5'd1, 5'd2);
    step();
    check("pre_rst_busy", busy, 32'h18);
    check("pre_rst_valid", {31'b0, issue_valid}, 32'd1);
    instr = vop(6'h00, 3'd0, 5'd5, 5'd1, 5'd2); rst = 1'b1;
    step(); rst = 1'b0;
    check("mid_rst_busy", busy, 32'h0);
    check("mid_rst_valid", {31'b0, issue_valid}, 32'd0);
    check("mid_rst_vd", {27'b0, issue_vd}, 32'd0);
    check("mid_rst_stall_cycles", stall_cycles, 32'd0);
    step(); empty = 1'b1;
    check("post_rst_valid", {31'b0, issue_valid}, 32'd1);
    check("post_rst_vd", {27'b0, issue_vd}, 32'd5);
    check("post_rst_vl", {26'b0, issue_vl}, 32'd32);
    check("post_rst_vl16", {27'b0, issue_vl16}, 32'd16);
    wb_valid = 1'b1; wb_vd = 5'd3;
    step(); wb_valid = 1'b0;
    check("stale_wb", busy, 32'h20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
